// File: rtl/sha256_avalon_pkg.sv
// Shared constants for the multi-block SHA-256 Avalon wrapper: register map,
// CTRL/STATUS bit positions, FSM encoding and the SHA-256 round helpers.
package sha256_avalon_pkg;

  localparam logic [7:0] MSG_BASE    = 8'h00;
  localparam logic [7:0] CTRL_ADDR   = 8'h10;
  localparam logic [7:0] STATUS_ADDR = 8'h11;
  localparam logic [7:0] DIGEST_BASE = 8'h80;

  localparam int CTRL_COMMIT   = 0;
  localparam int CTRL_LAST     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_SOFT_CLR = 3;

  localparam int ST_BUSY  = 0;
  localparam int ST_DV    = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_EMPTY = 3;
  localparam int ST_COUNT = 4;
  localparam int ST_IRQ   = 8;
  localparam int ST_OVF   = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DRAIN = 2'd3
  } fsm_t;

  localparam logic [255:0] IV_TBL = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [2047:0] K_TBL = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] k_of(input logic [5:0] i);
    return K_TBL[{~i, 5'b0} +: 32];
  endfunction

  function automatic logic [31:0] iv_of(input int i);
    return IV_TBL[(7-i)*32 +: 32];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sm_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sm_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// Circular buffer of 512-bit message blocks with per-slot last flags.
// Writes only ever target wr_ptr, so the slot being hashed is never disturbed.
module sha256_block_buffer #(
  parameter  int NUM_SLOTS = 2,
  localparam int PW = $clog2(NUM_SLOTS),
  localparam int CW = PW + 1
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [3:0]    wr_idx,
  input  logic [31:0]   wr_data,
  input  logic          commit,
  input  logic          commit_last,
  input  logic          pop,
  input  logic          ovf_clr,
  output logic [511:0]  rd_block,
  output logic          rd_last,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  logic [15:0][31:0]    slots [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] last_f;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 do_push, do_pop;

  assign full     = (count == CW'(NUM_SLOTS));
  assign empty    = (count == '0);
  assign do_push  = commit && !full;
  assign do_pop   = pop && !empty;
  assign rd_block = slots[rd_ptr];
  assign rd_last  = last_f[rd_ptr];

  // slot storage; word 0 lands in the most significant position
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) slots[s] <= '0;
      last_f <= '0;
    end else begin
      if (wr_en && !full) slots[wr_ptr][4'd15 - wr_idx] <= wr_data;
      if (do_push) last_f[wr_ptr] <= commit_last;
    end
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if ((wr_en || commit) && full) overflow <= 1'b1;
      else if (ovf_clr)              overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/sha256_core.sv
// Iterative SHA-256 compression, one round per clock. The chaining value is
// re-seeded with the IV on the first block after reset, after a last block,
// or after a restart request.
module sha256_core
  import sha256_avalon_pkg::*;
(
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         start,
  input  logic         restart,
  input  logic         last_block,
  input  logic [511:0] block,
  output logic         done,
  output logic [255:0] digest
);

  logic [31:0] hv [8];
  logic [31:0] v  [8];
  logic [31:0] w  [16];
  logic [5:0]  rnd;
  logic        busy, fresh, last_r;
  logic [31:0] t1, t2, w_nxt;

  // round datapath and message schedule
  always_comb begin
    t1    = v[7] + big_s1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_of(rnd) + w[0];
    t2    = big_s0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    w_nxt = sm_s1(w[14]) + w[9] + sm_s0(w[1]) + w[0];
  end

  // load, iterate 64 rounds, fold into chaining value
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < 8; i++) begin
        hv[i] <= '0;
        v[i]  <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
      rnd    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fresh  <= 1'b1;
      last_r <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
        for (int i = 0; i < 8; i++) begin
          v[i] <= fresh ? iv_of(i) : hv[i];
          if (fresh) hv[i] <= iv_of(i);
        end
        rnd    <= '0;
        busy   <= 1'b1;
        fresh  <= 1'b0;
        last_r <= last_block;
      end else if (busy) begin
        v[0] <= t1 + t2;
        v[1] <= v[0];
        v[2] <= v[1];
        v[3] <= v[2];
        v[4] <= v[3] + t1;
        v[5] <= v[4];
        v[6] <= v[5];
        v[7] <= v[6];
        for (int i = 0; i < 15; i++) w[i] <= w[i+1];
        w[15] <= w_nxt;
        rnd   <= rnd + 6'd1;
        if (rnd == 6'd63) begin
          hv[0] <= hv[0] + t1 + t2;
          hv[1] <= hv[1] + v[0];
          hv[2] <= hv[2] + v[1];
          hv[3] <= hv[3] + v[2];
          hv[4] <= hv[4] + v[3] + t1;
          hv[5] <= hv[5] + v[4];
          hv[6] <= hv[6] + v[5];
          hv[7] <= hv[7] + v[6];
          busy  <= 1'b0;
          done  <= 1'b1;
          fresh <= last_r;
        end
      end
      // a restart forces the next block to begin a new message
      if (restart) begin
        fresh  <= 1'b1;
        last_r <= 1'b1;
      end
    end
  end

  assign digest = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};

endmodule

// File: rtl/sha256_avalon_mb.sv
// Avalon-MM slave around sha256_core: buffers message blocks, dispatches them
// automatically, and keeps a stable snapshot of the final digest.
module sha256_avalon_mb
  import sha256_avalon_pkg::*;
#(
  parameter int NUM_SLOTS = 2
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipSelect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [7:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oIrq
);

  localparam int CW = $clog2(NUM_SLOTS) + 1;

  logic              sel_wr, sel_rd, msg_wr, ctrl_wr, stat_wr;
  logic              commit, soft_clr;
  fsm_t              state;
  logic              first_f, dv, irq_p, irq_en, busy;
  logic [255:0]      snap;
  logic [7:0][31:0]  snap_w;
  logic [511:0]      rd_block;
  logic              rd_last, full, empty, overflow;
  logic [CW-1:0]     count;
  logic              core_start, core_done, pop;
  logic [255:0]      core_digest;
  logic [31:0]       rmux;

  assign sel_wr     = !iChipSelect_n && !iWrite_n;
  assign sel_rd     = !iChipSelect_n && !iRead_n;
  assign msg_wr     = sel_wr && (iAddress[7:4] == MSG_BASE[7:4]);
  assign ctrl_wr    = sel_wr && (iAddress == CTRL_ADDR);
  assign stat_wr    = sel_wr && (iAddress == STATUS_ADDR);
  assign commit     = ctrl_wr && iData[CTRL_COMMIT];
  assign soft_clr   = ctrl_wr && iData[CTRL_SOFT_CLR];
  assign busy       = (state != S_IDLE);
  assign core_start = (state == S_START);
  assign pop        = (state == S_BUSY) && core_done;
  assign snap_w     = snap;
  assign oIrq       = irq_p && irq_en;

  sha256_block_buffer #(.NUM_SLOTS(NUM_SLOTS)) u_buf (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .clr         (soft_clr),
    .wr_en       (msg_wr),
    .wr_idx      (iAddress[3:0]),
    .wr_data     (iData),
    .commit      (commit),
    .commit_last (iData[CTRL_LAST]),
    .pop         (pop),
    .ovf_clr     (stat_wr && iData[ST_OVF]),
    .rd_block    (rd_block),
    .rd_last     (rd_last),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow)
  );

  sha256_core u_core (
    .iClk       (iClk),
    .iReset_n   (iReset_n),
    .start      (core_start),
    .restart    (soft_clr),
    .last_block (rd_last),
    .block      (rd_block),
    .done       (core_done),
    .digest     (core_digest)
  );

  // dispatch FSM, digest snapshot and interrupt state; sets override W1C
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state   <= S_IDLE;
      first_f <= 1'b1;
      dv      <= 1'b0;
      irq_p   <= 1'b0;
      irq_en  <= 1'b0;
      snap    <= '0;
    end else begin
      if (ctrl_wr) irq_en <= iData[CTRL_IRQ_EN];
      if (stat_wr && iData[ST_IRQ]) irq_p <= 1'b0;
      case (state)
        S_IDLE:  if (count != '0 && !soft_clr) state <= S_START;
        S_START: begin
          if (first_f) dv <= 1'b0;
          first_f <= 1'b0;
          state   <= soft_clr ? S_DRAIN : S_BUSY;
        end
        S_BUSY: begin
          if (soft_clr) state <= core_done ? S_IDLE : S_DRAIN;
          else if (core_done) begin
            state <= S_IDLE;
            if (rd_last) begin
              snap    <= core_digest;
              dv      <= 1'b1;
              irq_p   <= 1'b1;
              first_f <= 1'b1;
            end
          end
        end
        default: if (core_done) state <= S_IDLE;
      endcase
      if (soft_clr) begin
        dv      <= 1'b0;
        irq_p   <= 1'b0;
        first_f <= 1'b1;
      end
    end
  end

  // read decode
  always_comb begin
    rmux = '0;
    if (iAddress == CTRL_ADDR) begin
      rmux[CTRL_IRQ_EN] = irq_en;
    end else if (iAddress == STATUS_ADDR) begin
      rmux[ST_BUSY]       = busy;
      rmux[ST_DV]         = dv;
      rmux[ST_FULL]       = full;
      rmux[ST_EMPTY]      = empty;
      rmux[ST_COUNT +: 4] = 4'(count);
      rmux[ST_IRQ]        = irq_p;
      rmux[ST_OVF]        = overflow;
    end else if (iAddress[7:3] == DIGEST_BASE[7:3]) begin
      rmux = snap_w[3'd7 - iAddress[2:0]];
    end
  end

  // registered read data, zero when no read was sampled
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) oData <= '0;
    else           oData <= sel_rd ? rmux : '0;
  end

endmodule
